// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through a single
// structural full-adder slice, with a start/busy/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    half_adder ha0 (.x(a),    .y(b),   .s(s1_s), .c(c1_s));
    half_adder ha1 (.x(s1_s), .y(cin), .s(sum),  .c(c2_s));

    assign cout = c1_s | c2_s;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] acc_r;
    logic             c_q_r;
    logic [CW-1:0]    cnt_r;

    logic             s_bit_s;
    logic             c_nxt_s;
    logic             load_s;
    logic             last_s;

    full_adder_structural slice (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (c_q_r),
        .sum  (s_bit_s),
        .cout (c_nxt_s)
    );

    // Accept decode: start only counts in IDLE or DONE; a start during SHIFT is dropped.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            IDLE:    load_s = start;
            DONE:    load_s = start;
            default: load_s = 1'b0;
        endcase
        last_s = (cnt_r == CNT_LAST);
    end

    // Control FSM, operand shifters, accumulator and registered handshake/results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            acc_r   <= '0;
            c_q_r   <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (load_s) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        c_q_r   <= cin;
                        cnt_r   <= '0;
                        acc_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    // New sum bit enters at the MSB so bit 0 lands at acc[0] after WIDTH shifts.
                    acc_r  <= {s_bit_s, acc_r[WIDTH-1:1]};
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    c_q_r  <= c_nxt_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        sum     <= {s_bit_s, acc_r[WIDTH-1:1]};
                        cout    <= c_nxt_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
